// File: rtl/qq_rd_ctl.sv
// QuickQ sequencing controller: owns head/tail/occupancy of a D-entry circular queue
// and steers the storage write port and the read-address incrementer (single push, dual pop).
module qq_rd_ctl #(
    parameter  int D  = 4,
    localparam int DW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [1:0]    pop_req,
    input  logic          flush,
    output logic          we,
    output logic [DW-1:0] wr_addr,
    output logic [DW-1:0] base_addr,
    output logic [1:0]    incr_ctl,
    output logic [1:0]    pop_ack,
    output logic [DW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          err_ovf,
    output logic          err_udf
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [DW:0]   count_q, count_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_udf_q, err_udf_d;

    logic [1:0]    pop_sat;
    logic [DW:0]   pop_ext;
    logic [1:0]    grant;
    logic          push_acc;
    logic          full_w;

    assign full_w  = (state_q == ST_FULL);
    assign pop_sat = (pop_req == 2'd3) ? 2'd2 : pop_req;
    assign pop_ext = (DW+1)'(pop_sat);
    // Grant is limited by the registered occupancy; a same-cycle push never feeds a pop.
    assign grant   = (pop_ext > count_q) ? count_q[1:0] : pop_sat;

    always_comb begin
        we        = 1'b0;
        pop_ack   = 2'd0;
        incr_ctl  = 2'd0;
        base_addr = head_q;
        push_acc  = 1'b0;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q;
        err_udf_d = err_udf_q;

        if (!rst) begin
            // Incrementer loads zero on every edge while reset is held.
            base_addr = '0;
        end else if (flush) begin
            base_addr = tail_q;
            head_d    = tail_q;
            count_d   = '0;
        end else begin
            push_acc  = push && (!full_w || (grant != 2'd0));
            we        = push_acc;
            pop_ack   = grant;
            incr_ctl  = grant;
            if (push_acc) begin
                tail_d = tail_q + 1'b1;
            end
            head_d  = head_q + DW'(grant);
            count_d = count_q + (DW+1)'(push_acc) - (DW+1)'(grant);
            if (push && full_w && (grant == 2'd0)) begin
                err_ovf_d = 1'b1;
            end
            if (pop_ext > count_q) begin
                err_udf_d = 1'b1;
            end
        end
    end

    always_comb begin
        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d == (DW+1)'(D)) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_EMPTY;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign wr_addr = tail_q;
    assign count   = count_q;
    assign empty   = (state_q == ST_EMPTY);
    assign full    = full_w;
    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;

endmodule

// File: tb/tb_qq_rd_ctl.sv
// Directed bench for qq_rd_ctl with D=4: fill, dual pop, push-while-full, wrap,
// underflow, flush and asynchronous reset mid-stream.
module tb_qq_rd_ctl;

    localparam int D  = 4;
    localparam int DW = $clog2(D);

    logic          clk;
    logic          rst;
    logic          push;
    logic [1:0]    pop_req;
    logic          flush;
    logic          we;
    logic [DW-1:0] wr_addr;
    logic [DW-1:0] base_addr;
    logic [1:0]    incr_ctl;
    logic [1:0]    pop_ack;
    logic [DW:0]   count;
    logic          empty;
    logic          full;
    logic          err_ovf;
    logic          err_udf;

    int checks = 0;
    int errors = 0;

    qq_rd_ctl #(.D(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop_req   (pop_req),
        .flush     (flush),
        .we        (we),
        .wr_addr   (wr_addr),
        .base_addr (base_addr),
        .incr_ctl  (incr_ctl),
        .pop_ack   (pop_ack),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .err_ovf   (err_ovf),
        .err_udf   (err_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic [1:0] pr, input logic f);
        push    = p;
        pop_req = pr;
        flush   = f;
        #1;
    endtask

    task automatic chk_state(input string tag, input int c, input logic e, input logic fl,
                             input logic ov, input logic ud);
        chk({tag, ".count"}, count, c);
        chk({tag, ".empty"}, empty, e);
        chk({tag, ".full"},  full,  fl);
        chk({tag, ".ovf"},   err_ovf, ov);
        chk({tag, ".udf"},   err_udf, ud);
        $display("step %s: count=%0d empty=%0b full=%0b ovf=%0b udf=%0b",
                 tag, count, empty, full, err_ovf, err_udf);
    endtask

    initial begin
        rst = 1'b0;
        push = 1'b0; pop_req = 2'd0; flush = 1'b0;
        #2;
        drive(1'b1, 2'd2, 1'b0);
        chk("rst.we", we, 0);
        chk("rst.pop_ack", pop_ack, 0);
        chk("rst.base", base_addr, 0);
        chk("rst.incr", incr_ctl, 0);
        chk_state("rst", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_state("rst_hold", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0);
        rst = 1'b1;

        // Fill: tail 0..3, head stays 0.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd0, 1'b0);
            chk("fill.we", we, 1);
            chk("fill.wr_addr", wr_addr, i);
            chk("fill.base", base_addr, 0);
            chk("fill.incr", incr_ctl, 0);
            tick();
        end
        drive(1'b0, 2'd0, 1'b0);
        chk_state("filled", 4, 1'b0, 1'b1, 1'b0, 1'b0);

        // Dual pop from full, head 0 -> 2.
        drive(1'b0, 2'd2, 1'b0);
        chk("pop2.ack", pop_ack, 2);
        chk("pop2.incr", incr_ctl, 2);
        chk("pop2.base", base_addr, 0);
        tick();
        drive(1'b0, 2'd0, 1'b0);
        chk("pop2.head", base_addr, 2);
        chk_state("pop2", 2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Refill to full: wr_addr wraps 0,1 (tail ends at 2).
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'd0, 1'b0);
            chk("refill.wr_addr", wr_addr, i);
            tick();
        end
        drive(1'b0, 2'd0, 1'b0);
        chk_state("refull", 4, 1'b0, 1'b1, 1'b0, 1'b0);

        // Full + push + pop1: accepted, count stays 4.
        drive(1'b1, 2'd1, 1'b0);
        chk("fpp.we", we, 1);
        chk("fpp.wr_addr", wr_addr, 2);
        chk("fpp.ack", pop_ack, 1);
        chk("fpp.base", base_addr, 2);
        chk("fpp.incr", incr_ctl, 1);
        tick();
        chk_state("fpp", 4, 1'b0, 1'b1, 1'b0, 1'b0);

        // Full + push alone: dropped, overflow sticky.
        drive(1'b1, 2'd0, 1'b0);
        chk("ovf.we", we, 0);
        chk("ovf.ack", pop_ack, 0);
        tick();
        drive(1'b0, 2'd0, 1'b0);
        chk_state("ovf", 4, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovf.head", base_addr, 3);
        chk("ovf.tail", wr_addr, 3);
        tick();
        chk_state("ovf_sticky", 4, 1'b0, 1'b1, 1'b1, 1'b0);

        // Wrap: head 3 pop 2 -> head 1.
        drive(1'b0, 2'd2, 1'b0);
        chk("wrap.base", base_addr, 3);
        tick();
        drive(1'b0, 2'd0, 1'b0);
        chk("wrap.head", base_addr, 1);
        chk_state("wrap", 2, 1'b0, 1'b0, 1'b1, 1'b0);

        // pop_req=3 saturates to 2, but only 2 entries remain... use pop 1 to reach count 1.
        drive(1'b0, 2'd1, 1'b0);
        tick();
        drive(1'b0, 2'd0, 1'b0);
        chk("p1.head", base_addr, 2);
        chk_state("p1", 1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Underflow: count 1, pop_req 3 (treated as 2) -> grant 1.
        drive(1'b0, 2'd3, 1'b0);
        chk("udf.ack", pop_ack, 1);
        chk("udf.incr", incr_ctl, 1);
        chk("udf.base", base_addr, 2);
        tick();
        drive(1'b0, 2'd0, 1'b0);
        chk("udf.head", base_addr, 3);
        chk_state("udf", 0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Refill two (wr 3, 0) -> head 3, tail 1, count 2.
        drive(1'b1, 2'd0, 1'b0);
        chk("pre_fl.wr0", wr_addr, 3);
        tick();
        drive(1'b1, 2'd0, 1'b0);
        chk("pre_fl.wr1", wr_addr, 0);
        tick();

        // Flush with push and pop: everything ignored, head jumps to tail.
        drive(1'b1, 2'd2, 1'b1);
        chk("fl.we", we, 0);
        chk("fl.ack", pop_ack, 0);
        chk("fl.base", base_addr, 1);
        chk("fl.incr", incr_ctl, 0);
        tick();
        drive(1'b0, 2'd0, 1'b0);
        chk("fl.head", base_addr, 1);
        chk("fl.tail", wr_addr, 1);
        chk_state("fl", 0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Push and pop at count 0: no grant, push accepted.
        drive(1'b1, 2'd1, 1'b0);
        chk("p0.ack", pop_ack, 0);
        chk("p0.we", we, 1);
        chk("p0.wr", wr_addr, 1);
        tick();
        drive(1'b1, 2'd0, 1'b0);
        tick();
        tick();
        drive(1'b0, 2'd0, 1'b0);
        chk_state("pre_rst", 3, 1'b0, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset between edges.
        push = 1'b1;
        rst  = 1'b0;
        #1;
        chk("arst.we", we, 0);
        chk("arst.base", base_addr, 0);
        chk("arst.incr", incr_ctl, 0);
        chk_state("arst", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_state("arst_edge", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 2'd0, 1'b0);
        chk("post.we", we, 1);
        chk("post.wr", wr_addr, 0);
        tick();
        drive(1'b0, 2'd0, 1'b0);
        chk_state("post", 1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
